adder_serializer: RTL

//   Upstream feeder for the sequential serial adder. Accepts a parallel operand

---
 rtl/adder_serializer_if.sv | 24 ++
 rtl/adder_serializer.sv | 114 +++++++++++
 2 files changed

// File: rtl/adder_serializer_if.sv
// Handshake and serial-output bundle between an upstream word source and the
// adder serializer; the serializer sits on the slave side.
interface adder_serializer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             b;
  logic             bit_valid;
  logic             first_bit;
  logic             last_bit;
  logic             busy;

  modport slave (
    input  in_valid, in_data,
    output in_ready, b, bit_valid, first_bit, last_bit, busy
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, b, bit_valid, first_bit, last_bit, busy
  );
endinterface

// File: rtl/adder_serializer.sv
// Serial feeder for the sequential adder: takes a parallel word over valid/ready,
// shifts it out LSB-first on b, then drives GAP zero bits so the adder resets.
module adder_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 2
) (
  input logic                clk,
  input logic                reset,
  adder_serializer_if.slave  bus
);

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count, count_nx, count_inc;
  logic [WIDTH-1:0] shreg, shreg_nx, shifted;
  logic             b_nx, valid_nx, first_nx, last_nx;
  logic             b_q, valid_q, first_q, last_q, busy_q;

  assign count_inc = count + ONE;
  assign shifted   = shreg >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= '0;
      shreg   <= '0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      shreg   <= shreg_nx;
      b_q     <= b_nx;
      valid_q <= valid_nx;
      first_q <= first_nx;
      last_q  <= last_nx;
      busy_q  <= (state_nx != S_IDLE);
    end
  end

  // Next-state logic also computes the bit to present next cycle, so every
  // serial output comes straight from a flop.
  always_comb begin
    state_nx = state;
    count_nx = count;
    shreg_nx = shreg;
    b_nx     = 1'b0;
    valid_nx = 1'b0;
    first_nx = 1'b0;
    last_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nx = S_SHIFT;
          count_nx = '0;
          shreg_nx = bus.in_data;
          b_nx     = bus.in_data[0];
          valid_nx = 1'b1;
          first_nx = 1'b1;
          last_nx  = (WIDTH == 1);
        end
      end
      S_SHIFT: begin
        if (count == LAST_BIT) begin
          count_nx = '0;
          shreg_nx = '0;
          state_nx = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          count_nx = count_inc;
          shreg_nx = shifted;
          b_nx     = shifted[0];
          valid_nx = 1'b1;
          last_nx  = (count_inc == LAST_BIT);
        end
      end
      S_GAP: begin
        if (count == LAST_GAP) begin
          count_nx = '0;
          state_nx = S_IDLE;
        end else begin
          count_nx = count_inc;
        end
      end
      default: begin
        state_nx = S_IDLE;
        count_nx = '0;
        shreg_nx = '0;
      end
    endcase
  end

  // Ready is the only combinational output; it must drop with reset at once.
  assign bus.in_ready  = (state == S_IDLE) && reset;
  assign bus.b         = b_q;
  assign bus.bit_valid = valid_q;
  assign bus.first_bit = first_q;
  assign bus.last_bit  = last_q;
  assign bus.busy      = busy_q;

endmodule
